// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: FSM encoding, word width and
// the array index-width helper.
package mem_responder_pkg;

   localparam int WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT    = 2'd1,
      RESPOND = 2'd2
   } state_t;

   // Number of index bits needed to address a word array of the given depth.
   function automatic int index_width(input int depth_words);
      return (depth_words > 1) ? $clog2(depth_words) : 1;
   endfunction

endpackage

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word array. No reset: contents are undefined until
// written. Read data is registered on every edge from the presented index.
module mem_array
   import mem_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int INDEX_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  writeEnable,
   input  logic [INDEX_WIDTH-1:0] index,
   input  logic [WORD_WIDTH-1:0] writeData,
   output logic [WORD_WIDTH-1:0] readData
);

   logic [WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];
   logic [WORD_WIDTH-1:0] rdata_q;

   // Write port plus registered read (read returns the pre-write contents).
   always_ff @(posedge clk) begin
      if (writeEnable) begin
         mem_q[index] <= writeData;
      end
      rdata_q <= mem_q[index];
   end

   assign readData = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder: accepts one request in IDLE, waits a fixed
// number of cycles, performs the access and pulses ready for one cycle with
// read data (or write echo) and an address-error qualifier.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [WORD_WIDTH-1:0] writeData,
   output logic                  ready,
   output logic [WORD_WIDTH-1:0] readData,
   output logic                  addrError,
   output logic                  busy
);

   localparam int INDEX_WIDTH = index_width(DEPTH_WORDS);
   localparam int CNT_WIDTH   = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CNT_WIDTH-1:0]  CNT_LOAD    = CNT_WIDTH'(WAIT_CYCLES);
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE     = CNT_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH_WORDS);

   state_t                state_q, state_d;
   logic [CNT_WIDTH-1:0]  count_q, count_d;
   logic                  lat_we_q, lat_we_d;
   logic [ADDR_WIDTH-1:0] lat_addr_q, lat_addr_d;
   logic [WORD_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
   logic                  ready_q, ready_d;
   logic                  busy_q, busy_d;
   logic                  addr_err_q, addr_err_d;
   logic [WORD_WIDTH-1:0] hold_data_q, hold_data_d;
   logic                  from_array_q, from_array_d;

   logic                  acc_we;
   logic [ADDR_WIDTH-1:0] acc_addr;
   logic [WORD_WIDTH-1:0] acc_wdata;
   logic [ADDR_WIDTH-1:0] acc_word;
   logic                  acc_valid;
   logic                  access_fire;
   logic                  array_we;
   logic [WORD_WIDTH-1:0] array_rdata;

   // Access operands: live inputs when the access happens straight out of IDLE
   // (zero wait states), otherwise the request captured at acceptance.
   always_comb begin
      acc_we    = lat_we_q;
      acc_addr  = lat_addr_q;
      acc_wdata = lat_wdata_q;
      if (state_q == IDLE) begin
         acc_we    = we;
         acc_addr  = address;
         acc_wdata = writeData;
      end
   end

   assign acc_word  = acc_addr >> 2;
   assign acc_valid = (acc_addr[1:0] == 2'b00) && (acc_word < DEPTH_LIMIT);

   // Next-state, wait counter, request latch and response registers.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      lat_we_d     = lat_we_q;
      lat_addr_d   = lat_addr_q;
      lat_wdata_d  = lat_wdata_q;
      addr_err_d   = addr_err_q;
      hold_data_d  = hold_data_q;
      from_array_d = from_array_q;
      access_fire  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req) begin
               lat_we_d    = we;
               lat_addr_d  = address;
               lat_wdata_d = writeData;
               if (WAIT_CYCLES == 0) begin
                  state_d     = RESPOND;
                  access_fire = 1'b1;
               end else begin
                  state_d = WAIT;
                  count_d = CNT_LOAD;
               end
            end
         end
         WAIT: begin
            if (count_q == CNT_ONE) begin
               state_d     = RESPOND;
               count_d     = '0;
               access_fire = 1'b1;
            end else begin
               count_d = count_q - CNT_ONE;
            end
         end
         RESPOND: begin
            // Freeze whatever is being presented so readData holds after ready.
            state_d      = IDLE;
            hold_data_d  = readData;
            from_array_d = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (access_fire) begin
         addr_err_d   = !acc_valid;
         from_array_d = acc_valid && !acc_we;
         if (!acc_valid) begin
            hold_data_d = '0;
         end else if (acc_we) begin
            hold_data_d = acc_wdata;
         end
      end

      ready_d = (state_d == RESPOND);
      busy_d  = (state_d != IDLE);
   end

   // Never let a write land on the same edge that reset aborts the operation.
   assign array_we = access_fire && acc_valid && acc_we && !reset;

   // State and response registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         count_q      <= '0;
         lat_we_q     <= 1'b0;
         lat_addr_q   <= '0;
         lat_wdata_q  <= '0;
         ready_q      <= 1'b0;
         busy_q       <= 1'b0;
         addr_err_q   <= 1'b0;
         hold_data_q  <= '0;
         from_array_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         lat_we_q     <= lat_we_d;
         lat_addr_q   <= lat_addr_d;
         lat_wdata_q  <= lat_wdata_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
         addr_err_q   <= addr_err_d;
         hold_data_q  <= hold_data_d;
         from_array_q <= from_array_d;
      end
   end

   mem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .INDEX_WIDTH (INDEX_WIDTH)
   ) u_mem_array (
      .clk         (clk),
      .writeEnable (array_we),
      .index       (acc_word[INDEX_WIDTH-1:0]),
      .writeData   (acc_wdata),
      .readData    (array_rdata)
   );

   // Valid reads present the array's registered word during RESPOND; every
   // other case presents the held response value.
   assign readData  = from_array_q ? array_rdata : hold_data_q;
   assign ready     = ready_q;
   assign busy      = busy_q;
   assign addrError = addr_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: transaction-level model plus per-cycle comparison
// on the default build, and directed checks on a zero-wait-state build.
module tb_mem_responder;

   localparam int W     = 2;
   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        reset;
   logic        req, we;
   logic [31:0] address, writeData;
   logic        ready, addrError, busy;
   logic [31:0] readData;

   logic        req0, we0;
   logic [31:0] address0, writeData0;
   logic        ready0, addrError0, busy0;
   logic [31:0] readData0;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .address(address),
      .writeData(writeData), .ready(ready), .readData(readData),
      .addrError(addrError), .busy(busy)
   );

   mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .req(req0), .we(we0), .address(address0),
      .writeData(writeData0), .ready(ready0), .readData(readData0),
      .addrError(addrError0), .busy(busy0)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
   endtask

   // ---------------- transaction-level model ----------------
   int          edge_n = 0;
   bit          model_live = 0;
   int          next_free = 0;
   bit          pend_v = 0;
   int          pend_edge;
   bit          pend_we;
   logic [31:0] pend_addr, pend_data;
   logic [31:0] model_mem [int unsigned];
   bit          exp_ready = 0, exp_busy = 0, exp_err = 0, exp_rd_known = 0;
   logic [31:0] exp_rd = '0;

   initial begin
      forever begin
         @(posedge clk);
         edge_n++;
         if (reset) begin
            model_live   = 1;
            pend_v       = 0;
            exp_ready    = 0;
            exp_busy     = 0;
            exp_err      = 0;
            exp_rd       = '0;
            exp_rd_known = 1;
            next_free    = edge_n + 1;
         end else if (model_live) begin
            exp_ready = 0;
            if (req && edge_n >= next_free) begin
               pend_v    = 1;
               pend_edge = edge_n + W;
               pend_we   = we;
               pend_addr = address;
               pend_data = writeData;
               next_free = edge_n + W + 2;
            end
            if (pend_v && edge_n == pend_edge) begin
               if (pend_addr[1:0] != 2'b00 || (pend_addr >> 2) >= DEPTH) begin
                  exp_err = 1; exp_rd = '0; exp_rd_known = 1;
               end else if (pend_we) begin
                  model_mem[pend_addr >> 2] = pend_data;
                  exp_err = 0; exp_rd = pend_data; exp_rd_known = 1;
               end else begin
                  exp_err = 0;
                  exp_rd_known = model_mem.exists(pend_addr >> 2);
                  if (exp_rd_known) exp_rd = model_mem[pend_addr >> 2];
               end
               exp_ready = 1;
               pend_v    = 0;
            end
            exp_busy = pend_v || exp_ready;
         end
      end
   end

   // Per-cycle comparison of the default build against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (model_live) begin
            check("ready", {31'b0, ready}, {31'b0, exp_ready});
            check("busy", {31'b0, busy}, {31'b0, exp_busy});
            check("addrError", {31'b0, addrError}, {31'b0, exp_err});
            if (exp_rd_known) check("readData", readData, exp_rd);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output bit err, output int lat);
      int  start;
      bit  seen;
      @(negedge clk);
      req = 1; we = w; address = a; writeData = d;
      start = edge_n;
      seen = 0; rd = 'x; err = 0; lat = -1;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (ready) begin
            seen = 1; rd = readData; err = addrError; lat = edge_n - (start + 1);
         end
      end
      req = 0; we = 0;
      if (!seen) check("ready_timeout", 32'd0, 32'd1);
      $display("txn %s addr=%h wdata=%h -> rdata=%h err=%0d latency=%0d",
               w ? "WR" : "RD", a, d, rd, err, lat);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      bit          err;
      int          lat;
      logic [31:0] s_addr [4];
      logic [31:0] s_data [4];
      int          i, last;

      reset = 1; req = 0; we = 0; address = '0; writeData = '0;
      req0 = 0; we0 = 0; address0 = '0; writeData0 = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'b0, ready}, 32'd0);
      check("rst_readData", readData, 32'd0);
      reset = 0;

      // Basic write/read with latency.
      do_req(1, 32'h0, 32'h0A0A0A0A, rd, err, lat);
      do_req(1, 32'h10, 32'hDEADBEEF, rd, err, lat);
      check("wr10_echo", rd, 32'hDEADBEEF);
      check("wr10_err", {31'b0, err}, 32'd0);
      check("wr10_latency", lat, 32'd2);
      do_req(0, 32'h10, 32'h0, rd, err, lat);
      check("rd10_data", rd, 32'hDEADBEEF);
      check("rd10_latency", lat, 32'd2);

      // Misaligned read, then confirm no corruption.
      do_req(0, 32'h13, 32'h0, rd, err, lat);
      check("rd13_err", {31'b0, err}, 32'd1);
      check("rd13_data", rd, 32'd0);
      check("rd13_latency", lat, 32'd2);
      do_req(0, 32'h10, 32'h0, rd, err, lat);
      check("rd10_again", rd, 32'hDEADBEEF);

      // Out-of-range write must not alias onto word 0.
      do_req(1, 32'h400, 32'hBAD0BAD0, rd, err, lat);
      check("wr400_err", {31'b0, err}, 32'd1);
      check("wr400_data", rd, 32'd0);
      do_req(0, 32'h0, 32'h0, rd, err, lat);
      check("rd0_intact", rd, 32'h0A0A0A0A);

      // Back-to-back reads with req held and address scrambled mid-WAIT.
      s_addr = '{32'h40, 32'h44, 32'h48, 32'h4C};
      s_data = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      for (int k = 0; k < 4; k++) do_req(1, s_addr[k], s_data[k], rd, err, lat);
      do_req(1, 32'h7C, 32'h77777777, rd, err, lat);
      @(negedge clk);
      req = 1; we = 0; address = s_addr[0];
      i = 0; last = 0;
      for (int c = 0; c < 60 && i < 4; c++) begin
         @(negedge clk);
         if (ready) begin
            check("stream_data", readData, s_data[i]);
            if (i > 0) check("stream_spacing", edge_n - last, W + 2);
            $display("txn RD-stream addr=%h -> rdata=%h edge=%0d", s_addr[i], readData, edge_n);
            last = edge_n;
            i++;
            if (i < 4) address = s_addr[i];
            else req = 0;
         end else if (busy) begin
            address = 32'h7C;
         end
      end
      req = 0;
      if (i < 4) check("stream_timeout", i, 32'd4);

      // Reset on what would have been the access edge of a pending write.
      do_req(1, 32'h20, 32'hCAFEF00D, rd, err, lat);
      @(negedge clk);
      req = 1; we = 1; address = 32'h20; writeData = 32'h12345678;
      @(negedge clk);
      req = 0; we = 0;
      check("abort_busy", {31'b0, busy}, 32'd1);
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      check("abort_ready", {31'b0, ready}, 32'd0);
      check("abort_busy_after", {31'b0, busy}, 32'd0);
      $display("txn WR addr=00000020 wdata=12345678 aborted by reset");
      repeat (3) @(negedge clk);
      check("abort_no_ready", {31'b0, ready}, 32'd0);
      do_req(0, 32'h20, 32'h0, rd, err, lat);
      check("rd20_prior", rd, 32'hCAFEF00D);

      // Zero-wait-state build: ready rises on the acceptance edge.
      @(negedge clk);
      check("w0_idle_ready", {31'b0, ready0}, 32'd0);
      req0 = 1; we0 = 1; address0 = 32'h8; writeData0 = 32'h55AA55AA;
      @(negedge clk);
      check("w0_wr_ready", {31'b0, ready0}, 32'd1);
      check("w0_wr_busy", {31'b0, busy0}, 32'd1);
      check("w0_wr_echo", readData0, 32'h55AA55AA);
      check("w0_wr_err", {31'b0, addrError0}, 32'd0);
      $display("txn W0-WR addr=00000008 wdata=55aa55aa -> rdata=%h", readData0);
      req0 = 0; we0 = 0;
      @(negedge clk);
      check("w0_ready_fall", {31'b0, ready0}, 32'd0);
      check("w0_busy_fall", {31'b0, busy0}, 32'd0);
      check("w0_hold", readData0, 32'h55AA55AA);
      req0 = 1; address0 = 32'h8;
      @(negedge clk);
      check("w0_rd_ready", {31'b0, ready0}, 32'd1);
      check("w0_rd_data", readData0, 32'h55AA55AA);
      $display("txn W0-RD addr=00000008 -> rdata=%h", readData0);
      req0 = 0;
      @(negedge clk);
      req0 = 1; address0 = 32'h6;
      @(negedge clk);
      check("w0_mis_ready", {31'b0, ready0}, 32'd1);
      check("w0_mis_err", {31'b0, addrError0}, 32'd1);
      check("w0_mis_data", readData0, 32'd0);
      $display("txn W0-RD addr=00000006 -> rdata=%h err=%0d", readData0, addrError0);
      req0 = 0;
      repeat (2) @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
